// File: rtl/fifo_stream_reader.sv
// Prefetching reader: pulls words from a synchronous FIFO into a 3-entry buffer
// and presents them as a ready/valid stream. Macro FIFO_STREAM_READER_COUNT_EN
// enables the word_count transfer counter; otherwise word_count is tied to zero.
module fifo_stream_reader #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [15:0]           word_count
);

   localparam int unsigned DEPTH = 3;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned OCC_W = 3;

   logic [DATA_WIDTH-1:0] buf_q [DEPTH];
   logic [DATA_WIDTH-1:0] buf_d [DEPTH];
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      tail;
   logic [OCC_W-1:0]      occ;
   logic                  pending_q;
   logic                  valid_q, valid_d;
   logic                  pop, push;

   // Reads in flight count against capacity, so the buffer can never overflow.
   assign occ     = OCC_W'(count_q) + OCC_W'(pending_q);
   assign fifo_rd = !rst && en && !fifo_empty && (occ < OCC_W'(DEPTH));

   assign pop      = valid_q && m_tready;
   assign push     = pending_q;
   assign m_tvalid = valid_q;
   assign m_tdata  = buf_q[0];

   // Head-at-slot-0 shift buffer: pop shifts down, push lands after the survivors.
   always_comb begin
      buf_d = buf_q;
      tail  = count_q - CNT_W'(pop);
      if (pop) begin
         buf_d[0] = buf_q[1];
         buf_d[1] = buf_q[2];
      end
      if (push) begin
         case (tail)
            CNT_W'(0): buf_d[0] = fifo_data;
            CNT_W'(1): buf_d[1] = fifo_data;
            default:   buf_d[2] = fifo_data;
         endcase
      end
      count_d = tail + CNT_W'(push);
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q     <= '{default: '0};
         count_q   <= '0;
         pending_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         count_q   <= count_d;
         pending_q <= fifo_rd;
         valid_q   <= valid_d;
      end
   end

`ifdef FIFO_STREAM_READER_COUNT_EN
   localparam int unsigned WC_W = 16;

   logic [WC_W-1:0] wc_q, wc_d;

   // Free-running transfer counter; wraps naturally at 16 bits.
   always_comb begin
      wc_d = wc_q;
      if (pop) begin
         wc_d = wc_q + WC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wc_q <= '0;
      end else begin
         wc_q <= wc_d;
      end
   end

   assign word_count = wc_q;
`else
   assign word_count = 16'(0);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: models the upstream sync FIFO and
// checks stream order, latency, backpressure, enable gating and reset behaviour.
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [15:0] word_count;

   fifo_stream_reader #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests;
   int          n_fail;
   int          n_xfer;
   logic [31:0] src_q [$];
   logic [31:0] exp_q [$];
   logic        pend_tb;
   logic [31:0] rd_word;
   logic [15:0] wc_exp;
   logic        hold_prev;
   logic [31:0] hold_data;
   logic        s_rd, s_valid, s_xfer;
   logic [31:0] s_data;
   logic [15:0] s_wc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at posedge+1, sample and score at negedge.
   task automatic run_cycle(input logic r, input logic e, input logic rdy, input logic stall);
      logic next_pend;
      rst        = r;
      en         = e;
      m_tready   = rdy;
      fifo_empty = stall || (src_q.size() == 0);
      fifo_data  = rd_word;
      @(negedge clk);
      s_rd    = fifo_rd;
      s_valid = m_tvalid;
      s_data  = m_tdata;
      s_wc    = word_count;
      s_xfer  = m_tvalid && m_tready && !rst;
      check_eq("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
      check_eq("rd_while_rst", 32'(fifo_rd && rst), 32'd0);
      check_eq("valid_vs_model", 32'(m_tvalid), 32'(exp_q.size() != 0));
      check_eq("word_count", 32'(word_count), 32'(wc_exp));
      if (hold_prev) begin
         check_eq("hold_valid", 32'(m_tvalid), 32'd1);
         check_eq("hold_data", m_tdata, hold_data);
      end
      hold_prev = m_tvalid && !m_tready && !rst;
      hold_data = m_tdata;
      if (pend_tb && !rst) exp_q.push_back(fifo_data);
      if (s_xfer) begin
         n_xfer++;
         if (exp_q.size() != 0) check_eq("stream_data", m_tdata, exp_q.pop_front());
`ifdef FIFO_STREAM_READER_COUNT_EN
         wc_exp = wc_exp + 16'd1;
`endif
      end
      next_pend = fifo_rd;
      if (fifo_rd && src_q.size() != 0) rd_word = src_q.pop_front();
      @(posedge clk);
      pend_tb = next_pend;
      if (r) begin
         exp_q.delete();
         wc_exp    = 16'd0;
         hold_prev = 1'b0;
         pend_tb   = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      src_q.delete();
      run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (exp_q.size() != 0 || pend_tb || src_q.size() != 0); i++)
         run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("drain_done", 32'(exp_q.size() + src_q.size()), 32'd0);
   endtask

   initial begin
      int rd_cnt, k, first, last, base;
      n_tests = 0; n_fail = 0; n_xfer = 0;
      pend_tb = 1'b0; rd_word = 32'd0; wc_exp = 16'd0;
      hold_prev = 1'b0; hold_data = 32'd0;
      rst = 1'b1; en = 1'b0; m_tready = 1'b0; fifo_empty = 1'b1; fifo_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      do_reset();
      check_eq("rst_valid", 32'(s_valid), 32'd0);
      check_eq("rst_data", s_data, 32'd0);
      check_eq("rst_wc", 32'(s_wc), 32'd0);
      check_eq("rst_rd", 32'(s_rd), 32'd0);

      // Latency: fifo_rd in cycle 0, first data in cycle 2, back to back
      do_reset();
      src_q = '{32'h11, 32'h22, 32'h33};
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_rd_c0", 32'(s_rd), 32'd1);
      check_eq("lat_valid_c0", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_valid_c1", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_valid_c2", 32'(s_valid), 32'd1);
      check_eq("lat_data_c2", s_data, 32'h11);
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_data_c3", s_data, 32'h22);
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_data_c4", s_data, 32'h33);
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lat_valid_c5", 32'(s_valid), 32'd0);

      // Backpressure: fill to 3, hold word 0, then drain 1 per cycle
      do_reset();
      for (int i = 0; i < 8; i++) src_q.push_back(32'hA0 + 32'(i));
      rd_cnt = 0;
      repeat (8) begin
         run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
         rd_cnt += int'(s_rd);
      end
      check_eq("bp_rd_pulses", 32'(rd_cnt), 32'd3);
      check_eq("bp_head_valid", 32'(s_valid), 32'd1);
      check_eq("bp_head_data", s_data, 32'hA0);
      k = 0; first = -1; last = -1;
      for (int i = 0; i < 20; i++) begin
         run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
         if (s_xfer) begin
            check_eq("bp_order", s_data, 32'hA0 + 32'(k));
            if (first < 0) first = i;
            last = i;
            k++;
         end
      end
      check_eq("bp_count", 32'(k), 32'd8);
      check_eq("bp_rate", 32'(last - first), 32'd7);

      // Enable dropped for 4 cycles while streaming
      do_reset();
      for (int i = 0; i < 24; i++) src_q.push_back(32'h300 + 32'(i));
      k = 0;
      for (int i = 0; i < 30; i++) begin
         logic e;
         e = !(i >= 8 && i < 12);
         run_cycle(1'b0, e, 1'b1, 1'b0);
         if (!e) check_eq("en_off_rd", 32'(s_rd), 32'd0);
         if (s_xfer) begin
            check_eq("en_order", s_data, 32'h300 + 32'(k));
            k++;
         end
      end
      base = n_xfer;
      drain(40);
      check_eq("en_total", 32'(k + n_xfer - base), 32'd24);

      // Reset with two words buffered and one in flight
      do_reset();
      for (int i = 0; i < 8; i++) src_q.push_back(32'h400 + 32'(i));
      repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("mid_rst_valid", 32'(s_valid), 32'd0);
      check_eq("mid_rst_wc", 32'(s_wc), 32'd0);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
         if (s_xfer) begin
            check_eq("mid_rst_order", s_data, 32'h405 + 32'(k));
            k++;
         end
      end
      check_eq("mid_rst_count", 32'(k), 32'd3);

      // Random source stalls, backpressure and enable against the scoreboard
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         while (src_q.size() < 4) src_q.push_back($urandom());
         run_cycle(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 2) == 0);
      end
      src_q.delete();
      drain(40);

`ifdef FIFO_STREAM_READER_COUNT_EN
      // Counter wrap after 65537 transfers
      do_reset();
      base = n_xfer;
      for (int i = 0; i < 70000 && (n_xfer - base) < 65537; i++) begin
         while (src_q.size() < 4) src_q.push_back($urandom());
         run_cycle(1'b0, (n_xfer - base) < 65535, 1'b1, 1'b0);
      end
      check_eq("wrap_xfers", 32'(n_xfer - base), 32'd65537);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("wrap_wc", 32'(s_wc), 32'd1);
`else
      check_eq("wc_tied_zero", 32'(word_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
